mult_share_arb: RTL and testbench

- Shares one iterative shift-add multiplier among NREQ requesters using round-robin arbitration.
- Each requester presents two w-bit operands with a request. The arbiter grants one requester, runs the multiply over w cycles, then returns a 2w-bit product tagged with the requester id.
- Sits between several operand sources and the single multiplier resource on the datapath.

---
 rtl/mult_share_arb_pkg.sv | 17 +
 rtl/mult_share_arb_shift_add_mult.sv | 56 +++++
 rtl/mult_share_arb.sv | 132 +++++++++++++
 tb/tb_mult_share_arb.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mult_share_arb_pkg.sv
// Shared definitions for the round-robin shared multiplier.
// Contents:
//   state_t - arbiter FSM encoding (IDLE, MUL, DONE)
//   idw_of  - requester-id width for a given requester count (clog2, floor of 1)
package mult_share_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int idw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mult_share_arb_shift_add_mult.sv
// Iterative LSB-first shift-add multiplier, one partial product per cycle.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   start      - load a/b and clear the accumulator; steps begin next cycle
//   a, b       - unsigned w-bit operands
//   done       - high during the final (w-th) step
//   prod       - accumulator value after the current step; the full product
//                while done is high
module shift_add_mult #(
  parameter int w = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [w-1:0]   a,
  input  logic [w-1:0]   b,
  output logic           done,
  output logic [2*w-1:0] prod
);

  localparam int CW = (w > 1) ? $clog2(w) : 1;

  logic          r_run;
  logic [CW-1:0] r_cnt;
  logic [2*w-1:0] r_acc;
  logic [2*w-1:0] r_mcand;
  logic [w-1:0]   r_mplier;
  logic [2*w-1:0] w_acc_nxt;

  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign done      = r_run && (r_cnt == CW'(w - 1));
  // Exposing the next accumulator value lets the caller register the final
  // product on the same edge that completes the last step.
  assign prod      = w_acc_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run <= 1'b0;
      r_cnt <= '0;
      r_acc <= '0;
    end else if (start) begin
      r_run    <= 1'b1;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= {{w{1'b0}}, a};
      r_mplier <= b;
    end else if (r_run) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
      if (done) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin arbiter sharing one shift-add multiplier among NREQ requesters.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   req          - per-slot request vector
//   op_a, op_b   - packed operands, slot i at [i*w +: w]
//   gnt          - one-hot grant, combinational, in the operand-sampling cycle
//   busy         - high in MUL and DONE
//   res          - 2w-bit product, held until the next res_vld
//   res_vld      - one-cycle result strobe
//   res_id       - requester that owns res
module mult_share_arb
  import mult_share_arb_pkg::*;
#(
  parameter int w    = 4,
  parameter int NREQ = 2,
  parameter int IDW  = idw_of(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*w-1:0] op_a,
  input  logic [NREQ*w-1:0] op_b,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic [2*w-1:0]    res,
  output logic              res_vld,
  output logic [IDW-1:0]    res_id
);

  state_t         r_state;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_owner;
  logic [2*w-1:0] r_res;
  logic           r_res_vld;
  logic [IDW-1:0] r_res_id;
  logic           r_busy;

  logic [IDW-1:0] w_sel;
  logic [IDW-1:0] w_cand;
  logic [IDW-1:0] w_ptr_nxt;
  logic           w_found;
  logic           w_start;
  logic           w_done;
  logic [2*w-1:0] w_prod;
  int             w_idx;
  logic [w-1:0]   w_a_arr [NREQ];
  logic [w-1:0]   w_b_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_slot
    assign w_a_arr[g] = op_a[g*w +: w];
    assign w_b_arr[g] = op_b[g*w +: w];
  end

  // First set request scanning from r_ptr upward, wrapping modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = 0;
    w_cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      w_cand = IDW'(w_idx);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
    w_ptr_nxt = (int'(w_sel) == NREQ - 1) ? '0 : w_sel + IDW'(1);
    w_start   = (r_state == IDLE) && w_found;
    gnt       = '0;
    if (w_start) gnt[w_sel] = 1'b1;
  end

  shift_add_mult #(.w(w)) u_mult (
    .clk   (clk),
    .rst   (rst),
    .start (w_start),
    .a     (w_a_arr[w_sel]),
    .b     (w_b_arr[w_sel]),
    .done  (w_done),
    .prod  (w_prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_res     <= '0;
      r_res_vld <= 1'b0;
      r_res_id  <= '0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_res_vld <= 1'b0;
          if (w_found) begin
            r_owner <= w_sel;
            r_ptr   <= w_ptr_nxt;
            r_busy  <= 1'b1;
            r_state <= MUL;
          end
        end
        MUL: begin
          if (w_done) begin
            r_res     <= w_prod;
            r_res_id  <= r_owner;
            r_res_vld <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          r_res_vld <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= IDLE;
        end
        default: begin
          r_res_vld <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign res     = r_res;
  assign res_vld = r_res_vld;
  assign res_id  = r_res_id;

endmodule

// File: tb/tb_mult_share_arb.sv
module tb_mult_share_arb;

  logic       clk = 1'b0;
  logic       rst;
  int         checks = 0;
  int         failures = 0;

  // Default instance: w=4, NREQ=2
  logic [1:0] req;
  logic [7:0] op_a, op_b;
  logic [1:0] gnt;
  logic       busy;
  logic [7:0] res;
  logic       res_vld;
  logic       res_id;

  // Wide instance: w=6, NREQ=3
  logic [2:0]  req3;
  logic [17:0] op_a3, op_b3;
  logic [2:0]  gnt3;
  logic        busy3;
  logic [11:0] res3;
  logic        res_vld3;
  logic [1:0]  res_id3;

  always #5 clk = ~clk;

  mult_share_arb dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
    .gnt(gnt), .busy(busy), .res(res), .res_vld(res_vld), .res_id(res_id)
  );

  mult_share_arb #(.w(6), .NREQ(3)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .op_a(op_a3), .op_b(op_b3),
    .gnt(gnt3), .busy(busy3), .res(res3), .res_vld(res_vld3), .res_id(res_id3)
  );

  task automatic test_reset();
    rst = 1'b1; req = '0; op_a = '0; op_b = '0;
    req3 = '0; op_a3 = '0; op_b3 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (res !== 8'd0) begin failures++; $display("FAIL reset_res got=%0d exp=0", res); end
    checks++; if (res_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", res_vld); end
    checks++; if (res_id !== 1'b0) begin failures++; $display("FAIL reset_id got=%b exp=0", res_id); end
    checks++; if ({gnt3, busy3, res_vld3, res3, res_id3} !== '0) begin
      failures++; $display("FAIL reset_dut3 got=%h exp=0", {gnt3, busy3, res_vld3, res3, res_id3});
    end
  endtask

  // 5*10 on slot 0: grant in t, busy t+1..t+5, result 50 in t+5.
  task automatic test_single();
    @(negedge clk);
    req = 2'b01; op_a = {4'd0, 4'd5}; op_b = {4'd0, 4'd10};
    #1;
    checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL single_gnt got=%b exp=01", gnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_t got=%b exp=0", busy); end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      req = 2'b00;
      #1;
      checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL single_gnt_k%0d got=%b exp=00", k, gnt); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_k%0d got=%b exp=1", k, busy); end
      checks++; if (res_vld !== (k == 5)) begin failures++; $display("FAIL single_vld_k%0d got=%b exp=%b", k, res_vld, (k == 5)); end
      if (k == 5) begin
        checks++; if (res !== 8'd50) begin failures++; $display("FAIL single_res got=%0d exp=50", res); end
        checks++; if (res_id !== 1'b0) begin failures++; $display("FAIL single_id got=%b exp=0", res_id); end
      end
    end
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_after got=%b exp=0", busy); end
    checks++; if (res_vld !== 1'b0) begin failures++; $display("FAIL single_vld_after got=%b exp=0", res_vld); end
  endtask

  // Both slots held from reset: grants 0,1,0 every 6 cycles, results 21,225,21.
  task automatic test_round_robin();
    logic [1:0] exp_g;
    logic [7:0] exp_r;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    req = 2'b11; op_a = {4'd15, 4'd3}; op_b = {4'd15, 4'd7};
    for (int c = 0; c < 18; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      exp_g = (c % 6 != 0) ? 2'b00 : (((c / 6) % 2 == 0) ? 2'b01 : 2'b10);
      checks++; if (gnt !== exp_g) begin failures++; $display("FAIL rr_gnt_c%0d got=%b exp=%b", c, gnt, exp_g); end
      checks++; if (res_vld !== (c % 6 == 5)) begin failures++; $display("FAIL rr_vld_c%0d got=%b exp=%b", c, res_vld, (c % 6 == 5)); end
      if (c % 6 == 5) begin
        exp_r = ((c / 6) % 2 == 0) ? 8'd21 : 8'd225;
        checks++; if (res !== exp_r) begin failures++; $display("FAIL rr_res_c%0d got=%0d exp=%0d", c, res, exp_r); end
        checks++; if (res_id !== ((c / 6) % 2 == 1)) begin failures++; $display("FAIL rr_id_c%0d got=%b exp=%b", c, res_id, ((c / 6) % 2 == 1)); end
      end
    end
    @(negedge clk);
    req = 2'b00;
    #1;
    checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL rr_drop_gnt got=%b exp=00", gnt); end
  endtask

  // 0*13 on slot 1 gives 0 with id 1; then req=11 goes to slot 0 (ptr wrapped).
  task automatic test_zero_wrap();
    @(negedge clk);
    req = 2'b10; op_a = {4'd0, 4'd0}; op_b = {4'd13, 4'd0};
    #1;
    checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL zero_gnt got=%b exp=10", gnt); end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      req = 2'b00;
      #1;
      checks++; if (res_vld !== (k == 5)) begin failures++; $display("FAIL zero_vld_k%0d got=%b exp=%b", k, res_vld, (k == 5)); end
    end
    checks++; if (res !== 8'd0) begin failures++; $display("FAIL zero_res got=%0d exp=0", res); end
    checks++; if (res_id !== 1'b1) begin failures++; $display("FAIL zero_id got=%b exp=1", res_id); end
    @(negedge clk);
    req = 2'b11; op_a = {4'd9, 4'd2}; op_b = {4'd9, 4'd3};
    #1;
    checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL wrap_gnt got=%b exp=01", gnt); end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      req = 2'b00;
      #1;
    end
    checks++; if (res_vld !== 1'b1) begin failures++; $display("FAIL wrap_vld got=%b exp=1", res_vld); end
    checks++; if (res !== 8'd6) begin failures++; $display("FAIL wrap_res got=%0d exp=6", res); end
    checks++; if (res_id !== 1'b0) begin failures++; $display("FAIL wrap_id got=%b exp=0", res_id); end
  endtask

  // rst in the second MUL cycle of 10*13: no result, outputs cleared, ptr back to 0.
  task automatic test_reset_mid();
    @(negedge clk);
    req = 2'b01; op_a = {4'd0, 4'd10}; op_b = {4'd0, 4'd13};
    #1;
    checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL mid_gnt got=%b exp=01", gnt); end
    @(negedge clk); req = 2'b00;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    req = 2'b11;
    #1;
    checks++; if (res_vld !== 1'b0) begin failures++; $display("FAIL mid_vld got=%b exp=0", res_vld); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
    checks++; if (res !== 8'd0) begin failures++; $display("FAIL mid_res got=%0d exp=0", res); end
    checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL mid_regnt got=%b exp=01", gnt); end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      req = 2'b00;
      #1;
      checks++; if (res_vld !== (k == 5)) begin failures++; $display("FAIL mid_vld_k%0d got=%b exp=%b", k, res_vld, (k == 5)); end
    end
    checks++; if (res !== 8'd130) begin failures++; $display("FAIL mid_res_new got=%0d exp=130", res); end
  endtask

  // Ten idle cycles: nothing moves, res keeps 130.
  task automatic test_idle_hold();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      req = 2'b00;
      #1;
      checks++; if ({gnt, busy, res_vld} !== 4'b0000) begin
        failures++; $display("FAIL idle_ctl_k%0d got=%b exp=0000", k, {gnt, busy, res_vld});
      end
      checks++; if (res !== 8'd130) begin failures++; $display("FAIL idle_res_k%0d got=%0d exp=130", k, res); end
    end
  endtask

  // w=6, NREQ=3: 63*63 on slot 2 = 3969 after 7 cycles; later operand edits ignored.
  task automatic test_wide();
    @(negedge clk);
    req3 = 3'b100; op_a3 = {6'd63, 12'd0}; op_b3 = {6'd63, 12'd0};
    #1;
    checks++; if (gnt3 !== 3'b100) begin failures++; $display("FAIL wide_gnt got=%b exp=100", gnt3); end
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      req3 = 3'b000; op_a3 = {6'd1, 12'd0}; op_b3 = {6'd1, 12'd0};
      #1;
      checks++; if (res_vld3 !== (k == 7)) begin failures++; $display("FAIL wide_vld_k%0d got=%b exp=%b", k, res_vld3, (k == 7)); end
      checks++; if (busy3 !== 1'b1) begin failures++; $display("FAIL wide_busy_k%0d got=%b exp=1", k, busy3); end
    end
    checks++; if (res3 !== 12'd3969) begin failures++; $display("FAIL wide_res got=%0d exp=3969", res3); end
    checks++; if (res_id3 !== 2'd2) begin failures++; $display("FAIL wide_id got=%0d exp=2", res_id3); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_zero_wrap();
    test_reset_mid();
    test_idle_hold();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
